// File: rtl/ikari_vreg_pkg.sv
// Shared definitions for the video-register write scheduler: register
// address map, one-hot strobe encodings and the drain state type.
package ikari_vreg_pkg;

   // Target register addresses as seen on a_addr / b_addr.
   typedef enum logic [2:0] {
      REG_BSET = 3'd0,
      REG_SSET = 3'd1,
      REG_MSET = 3'd2,
      REG_F1SY = 3'd3,
      REG_F2SY = 3'd4
   } vreg_addr_e;

   // Strobe vector bit order: {F2SY, F1SY, MSET, SSET, BSET}.
   localparam int         NUM_STROBES = 5;
   localparam logic [4:0] STB_NONE    = 5'b00000;
   localparam logic [4:0] STB_BSET    = 5'b00001;
   localparam logic [4:0] STB_SSET    = 5'b00010;
   localparam logic [4:0] STB_MSET    = 5'b00100;
   localparam logic [4:0] STB_F1SY    = 5'b01000;
   localparam logic [4:0] STB_F2SY    = 5'b10000;

   // Queue entry is {addr[2:0], data[7:0]}.
   localparam int ENTRY_W = 11;

   typedef enum logic [1:0] {
      DRAIN_IDLE   = 2'd0,
      DRAIN_SETUP  = 2'd1,
      DRAIN_STROBE = 2'd2
   } drain_state_e;

   // Addresses 5..7 have no register behind them.
   function automatic logic addr_mapped(input logic [2:0] addr);
      return addr <= 3'd4;
   endfunction

   function automatic logic [NUM_STROBES-1:0] decode_strobe(input logic [2:0] addr);
      logic [NUM_STROBES-1:0] stb;
      stb = STB_NONE;
      case (addr)
         REG_BSET: stb = STB_BSET;
         REG_SSET: stb = STB_SSET;
         REG_MSET: stb = STB_MSET;
         REG_F1SY: stb = STB_F1SY;
         REG_F2SY: stb = STB_F2SY;
         default:  stb = STB_NONE;
      endcase
      return stb;
   endfunction

endpackage

// File: rtl/ikari_vreg_fifo.sv
// Pending-write queue. Power-of-two depth so pointers wrap naturally.
// When empty, a simultaneous push and pop passes the write data straight
// through to rd_data so the drain machine can start in the acceptance cycle.
module ikari_vreg_fifo
   import ikari_vreg_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = ENTRY_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic             full_reg;
   logic             empty_reg;
   logic             bypass;
   logic             do_push;
   logic             do_pop;

   // Qualify push/pop; an empty-queue push+pop never touches storage.
   always_comb begin
      bypass  = push && pop && empty_reg;
      do_push = push && !bypass && (!full_reg || pop);
      do_pop  = pop && !bypass && !empty_reg;
   end

   // Storage array; no reset so it maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

   // Pointers, occupancy and registered full/empty flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         full_reg   <= 1'b0;
         empty_reg  <= 1'b1;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10: begin
               count_reg <= count_reg + 1'b1;
               empty_reg <= 1'b0;
               full_reg  <= (count_reg == CNT_LAST);
            end
            2'b01: begin
               count_reg <= count_reg - 1'b1;
               full_reg  <= 1'b0;
               empty_reg <= (count_reg == CNT_ONE);
            end
            default: begin
            end
         endcase
      end
   end

   assign rd_data = empty_reg ? wr_data : mem[rd_ptr_reg];
   assign full    = full_reg;
   assign empty   = empty_reg;

endmodule

// File: rtl/ikari_vreg_write_sched.sv
// Video-register write scheduler: round-robin arbiter between two CPUs,
// a pending-write queue, and a SETUP/STROBE drain machine that presents
// data one cycle ahead of the one-hot register strobe.
module ikari_vreg_write_sched
   import ikari_vreg_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       a_req,
   input  logic [2:0] a_addr,
   input  logic [7:0] a_data,
   output logic       a_ack,
   input  logic       b_req,
   input  logic [2:0] b_addr,
   input  logic [7:0] b_data,
   output logic       b_ack,
   input  logic       hold,
   output logic [7:0] VD_out,
   output logic       BSET,
   output logic       SSET,
   output logic       MSET,
   output logic       F1SY,
   output logic       F2SY,
   output logic       busy
);

   logic                   last_b_reg;
   logic                   grant_a;
   logic                   grant_b;
   logic [2:0]             sel_addr;
   logic [7:0]             sel_data;
   logic                   pop_when_nonempty;
   logic                   accept;
   logic                   push;
   logic                   pop;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [ENTRY_W-1:0]     fifo_rd_data;
   drain_state_e           state_reg;
   drain_state_e           state_next;
   logic [7:0]             vd_reg;
   logic [2:0]             addr_reg;
   logic [NUM_STROBES-1:0] strobe_reg;

   // Arbitration and acceptance. A full queue accepts only when the drain
   // machine is popping this cycle; that term never depends on push, so
   // there is no combinational loop with the pop logic below.
   always_comb begin
      grant_a           = a_req && (!b_req || last_b_reg);
      grant_b           = b_req && !grant_a;
      sel_addr          = grant_a ? a_addr : b_addr;
      sel_data          = grant_a ? a_data : b_data;
      pop_when_nonempty = !hold && (state_reg != DRAIN_SETUP) && !fifo_empty;
      accept            = !reset && (grant_a || grant_b) &&
                          (!fifo_full || pop_when_nonempty);
      push              = accept && addr_mapped(sel_addr);
      a_ack             = accept && grant_a;
      b_ack             = accept && grant_b;
   end

   // Round-robin pointer: remembers whether B won the last acceptance.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_b_reg <= 1'b1;
      end else if (accept) begin
         last_b_reg <= grant_b;
      end
   end

   ikari_vreg_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (push),
      .wr_data ({sel_addr, sel_data}),
      .pop     (pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Drain state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= DRAIN_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Drain next-state and pop. Hold only blocks starting a new entry;
   // a write already in SETUP always proceeds to STROBE.
   always_comb begin
      state_next = state_reg;
      pop        = 1'b0;
      case (state_reg)
         DRAIN_IDLE, DRAIN_STROBE: begin
            if (!hold && (!fifo_empty || push)) begin
               pop        = 1'b1;
               state_next = DRAIN_SETUP;
            end else begin
               state_next = DRAIN_IDLE;
            end
         end
         DRAIN_SETUP: begin
            state_next = DRAIN_STROBE;
         end
         default: begin
            state_next = DRAIN_IDLE;
         end
      endcase
   end

   // Output datapath: data/address latch on pop, strobe one cycle later.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vd_reg     <= 8'h00;
         addr_reg   <= 3'd0;
         strobe_reg <= STB_NONE;
      end else begin
         if (pop) begin
            vd_reg   <= fifo_rd_data[7:0];
            addr_reg <= fifo_rd_data[10:8];
         end
         strobe_reg <= (state_reg == DRAIN_SETUP) ? decode_strobe(addr_reg) : STB_NONE;
      end
   end

   assign VD_out = vd_reg;
   assign BSET   = strobe_reg[0];
   assign SSET   = strobe_reg[1];
   assign MSET   = strobe_reg[2];
   assign F1SY   = strobe_reg[3];
   assign F2SY   = strobe_reg[4];
   assign busy   = !fifo_empty || (state_reg != DRAIN_IDLE);

endmodule
